// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
//   Two-requester APB master for the I2C register map. Requesters are
//   arbitrated round-robin. Each grant runs one APB SETUP/ACCESS transfer.
//   The winner then receives a one-cycle done pulse, its error flag and, on a
//   read, the sampled read data. The wait on pready is bounded by a timeout
//   (TIMEOUT = 0 disables the timeout).
//
//   Ports
//     pclk_i, preset_ni        clock, asynchronous active-low reset
//     reqN_valid_i             request pending (fields held stable until accepted)
//     reqN_write_i/addr/wdata  request direction, address and write data
//     reqN_ready_o             combinational accept strobe (IDLE, granted N only)
//     reqN_done_o/err_o        registered completion pulse, err = timeout abort
//     reqN_rdata_o             read data, updated with done on reads, else held
//     paddr_o/pwrite_o/pwdata_o/psel_o/penable_o   registered APB request
//     prdata_i/pready_i        APB response
//
//   state  | meaning
//   IDLE   | no transfer; grant and accept a requester
//   SETUP  | APB setup phase, psel=1 penable=0 (one cycle)
//   ACCESS | APB access phase, psel=1 penable=1, wait for pready or timeout
// ---------------------------------------------------------------------------
module apb_master_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk_i,
    input  logic                  preset_ni,

    input  logic                  req0_valid_i,
    input  logic                  req0_write_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_wdata_i,
    output logic                  req0_ready_o,
    output logic                  req0_done_o,
    output logic                  req0_err_o,
    output logic [DATA_WIDTH-1:0] req0_rdata_o,

    input  logic                  req1_valid_i,
    input  logic                  req1_write_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_wdata_i,
    output logic                  req1_ready_o,
    output logic                  req1_done_o,
    output logic                  req1_err_o,
    output logic [DATA_WIDTH-1:0] req1_rdata_o,

    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  psel_o,
    output logic                  penable_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    // Last low-pready count value before abort; unused when TIMEOUT == 0.
    localparam logic [7:0] TO_LAST = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

    state_e                state_q, state_d;
    logic                  rr_q, rr_d;          // 0 favours req0, 1 favours req1
    logic                  owner_q, owner_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [7:0]            tcnt_q, tcnt_d;
    logic                  done0_q, done0_d;
    logic                  done1_q, done1_d;
    logic                  err0_q, err0_d;
    logic                  err1_q, err1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic grant1;
    logic accept0;
    logic accept1;
    logic complete;
    logic abort;
    logic xfer_end;

    // Arbitration and handshake strobes
    always_comb begin
        grant1   = req1_valid_i & (~req0_valid_i | rr_q);
        accept0  = (state_q == ST_IDLE) & req0_valid_i & ~grant1;
        accept1  = (state_q == ST_IDLE) & grant1;
        complete = (state_q == ST_ACCESS) & pready_i;
        abort    = (state_q == ST_ACCESS) & ~pready_i & (TIMEOUT != 0) & (tcnt_q == TO_LAST);
        xfer_end = complete | abort;
    end

    assign req0_ready_o = accept0;
    assign req1_ready_o = accept1;

    // Next state, latched request fields and registered bus outputs
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tcnt_d    = tcnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept0) begin
                    owner_d = 1'b0;
                    write_d = req0_write_i;
                    addr_d  = req0_addr_i;
                    wdata_d = req0_wdata_i;
                    state_d = ST_SETUP;
                end else if (accept1) begin
                    owner_d = 1'b1;
                    write_d = req1_write_i;
                    addr_d  = req1_addr_i;
                    wdata_d = req1_wdata_i;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                tcnt_d  = 8'd0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (xfer_end) begin
                    state_d = ST_IDLE;
                end else if (tcnt_q != 8'hFF) begin
                    // saturate so TIMEOUT=0 waits forever without wrap-around
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        psel_d    = (state_d != ST_IDLE);
        penable_d = (state_d == ST_ACCESS);
    end

    // Completion reporting and round-robin update
    always_comb begin
        done0_d  = xfer_end & ~owner_q;
        done1_d  = xfer_end &  owner_q;
        err0_d   = abort & ~owner_q;
        err1_d   = abort &  owner_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (complete & ~write_q) begin
            if (owner_q) rdata1_d = prdata_i;
            else         rdata0_d = prdata_i;
        end
        // A lone requester always wins, so flipping only after the favoured
        // requester's own transfer cannot starve either side.
        rr_d = (xfer_end && (owner_q == rr_q)) ? ~rr_q : rr_q;
    end

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            state_q   <= ST_IDLE;
            rr_q      <= 1'b0;
            owner_q   <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            tcnt_q    <= 8'd0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            tcnt_q    <= tcnt_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // The latched fields are only loaded on accept, so they stay stable on
    // the bus for the whole SETUP/ACCESS span.
    assign paddr_o      = addr_q;
    assign pwrite_o     = write_q;
    assign pwdata_o     = wdata_q;
    assign psel_o       = psel_q;
    assign penable_o    = penable_q;
    assign req0_done_o  = done0_q;
    assign req1_done_o  = done1_q;
    assign req0_err_o   = err0_q;
    assign req1_err_o   = err1_q;
    assign req0_rdata_o = rdata0_q;
    assign req1_rdata_o = rdata1_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

    localparam int TO = 4;

    typedef struct {
        int         own;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       err;
        logic [7:0] rd0;
        logic [7:0] rd1;
    } exp_t;

    logic       pclk_i;
    logic       preset_ni;
    logic [1:0] rv;
    logic [1:0] rw;
    logic [7:0] ra [2];
    logic [7:0] rd [2];
    logic [1:0] rdy;
    logic       req0_done_o, req1_done_o, req0_err_o, req1_err_o;
    logic [7:0] req0_rdata_o, req1_rdata_o;
    logic       req0_ready_o, req1_ready_o;
    logic [7:0] paddr_o, pwdata_o, prdata_i;
    logic       pwrite_o, psel_o, penable_o, pready_i;

    exp_t       sb[$];
    int         acc_ord[$];
    logic [7:0] exp_rd [2];
    int         slv_wait;
    logic [7:0] slv_rdata;
    int         n_cmp;
    int         n_bad;

    assign rdy = {req1_ready_o, req0_ready_o};

    apb_master_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT(TO)) dut (
        .pclk_i       (pclk_i),
        .preset_ni    (preset_ni),
        .req0_valid_i (rv[0]),
        .req0_write_i (rw[0]),
        .req0_addr_i  (ra[0]),
        .req0_wdata_i (rd[0]),
        .req0_ready_o (req0_ready_o),
        .req0_done_o  (req0_done_o),
        .req0_err_o   (req0_err_o),
        .req0_rdata_o (req0_rdata_o),
        .req1_valid_i (rv[1]),
        .req1_write_i (rw[1]),
        .req1_addr_i  (ra[1]),
        .req1_wdata_i (rd[1]),
        .req1_ready_o (req1_ready_o),
        .req1_done_o  (req1_done_o),
        .req1_err_o   (req1_err_o),
        .req1_rdata_o (req1_rdata_o),
        .paddr_o      (paddr_o),
        .pwrite_o     (pwrite_o),
        .pwdata_o     (pwdata_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .prdata_i     (prdata_i),
        .pready_i     (pready_i)
    );

    initial begin
        pclk_i = 1'b0;
        forever #5 pclk_i = ~pclk_i;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired: got no finish, want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Slave: pready low for slv_wait ACCESS cycles, then high with slv_rdata.
    initial begin
        int acc_cnt;
        acc_cnt  = 0;
        pready_i = 1'b0;
        prdata_i = 8'hEE;
        forever begin
            @(posedge pclk_i);
            #1;
            if (psel_o && penable_o) begin
                pready_i = (acc_cnt >= slv_wait);
                prdata_i = pready_i ? slv_rdata : 8'hEE;
                acc_cnt++;
            end else begin
                acc_cnt  = 0;
                pready_i = 1'b0;
                prdata_i = 8'hEE;
            end
        end
    end

    // Scoreboard monitor: bus fields on the completing cycle, results on done.
    always @(negedge pclk_i) begin
        exp_t e;
        if (preset_ni) begin
            if (psel_o && penable_o && pready_i) begin
                if (sb.size() == 0) begin
                    chk("bus_without_request", {31'd0, psel_o}, 32'd0);
                end else begin
                    chk("bus_paddr", {24'd0, paddr_o}, {24'd0, sb[0].addr});
                    chk("bus_pwrite", {31'd0, pwrite_o}, {31'd0, sb[0].wr});
                    if (sb[0].wr) chk("bus_pwdata", {24'd0, pwdata_o}, {24'd0, sb[0].wdata});
                end
            end
            if (req0_done_o || req1_done_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {30'd0, req1_done_o, req0_done_o}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_vec", {30'd0, req1_done_o, req0_done_o}, (e.own == 1) ? 32'd2 : 32'd1);
                    chk("done_err", {31'd0, (e.own == 1) ? req1_err_o : req0_err_o}, {31'd0, e.err});
                    chk("rdata0", {24'd0, req0_rdata_o}, {24'd0, e.rd0});
                    chk("rdata1", {24'd0, req1_rdata_o}, {24'd0, e.rd1});
                end
            end
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic drive_req(input int n, input logic wr, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        bit   got;
        got   = 1'b0;
        rw[n] = wr;
        ra[n] = a;
        rd[n] = d;
        rv[n] = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge pclk_i);
            if (rdy[n]) begin
                got     = 1'b1;
                e.own   = n;
                e.wr    = wr;
                e.addr  = a;
                e.wdata = d;
                e.err   = (slv_wait >= TO);
                if (!wr && !e.err) exp_rd[n] = slv_rdata;
                e.rd0   = exp_rd[0];
                e.rd1   = exp_rd[1];
                sb.push_back(e);
                acc_ord.push_back(n);
            end
        end
        if (!got) chk("handshake_timeout", {31'd0, rdy[n]}, 32'd1);
        @(posedge pclk_i);
        #1;
        rv[n] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge pclk_i);
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
        @(posedge pclk_i);
        #1;
    endtask

    // Counts ACCESS cycles up to the done pulse, checking paddr stays put.
    task automatic measure_access(input logic [7:0] a, output int n);
        bit seen;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge pclk_i);
            if (psel_o && penable_o) begin
                n++;
                chk("access_paddr_stable", {24'd0, paddr_o}, {24'd0, a});
            end
            if (req0_done_o || req1_done_o) begin
                seen = 1'b1;
                chk("psel_after_done", {30'd0, psel_o, penable_o}, 32'd0);
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int nacc;
        n_cmp     = 0;
        n_bad     = 0;
        rv        = '0;
        rw        = '0;
        ra[0]     = '0;
        ra[1]     = '0;
        rd[0]     = '0;
        rd[1]     = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        slv_wait  = 0;
        slv_rdata = 8'h00;
        preset_ni = 1'b0;

        #23;
        chk("rst_bus", {paddr_o, pwdata_o, 6'd0, pwrite_o, psel_o}, 32'd0);
        chk("rst_req", {penable_o, req0_done_o, req1_done_o, req0_err_o, req1_err_o,
                        req0_ready_o, req1_ready_o, req0_rdata_o, req1_rdata_o}, 32'd0);
        @(negedge pclk_i);
        preset_ni = 1'b1;
        @(posedge pclk_i);
        #1;

        // 1: lone write from req0, cycle-exact latency
        fork
            drive_req(0, 1'b1, 8'h05, 8'h1F);
            begin
                @(negedge pclk_i);
                chk("t1_ready0_T", {31'd0, req0_ready_o}, 32'd1);
                chk("t1_ready1_T", {31'd0, req1_ready_o}, 32'd0);
                @(negedge pclk_i);
                chk("t1_setup", {30'd0, psel_o, penable_o}, 32'd2);
                @(negedge pclk_i);
                chk("t1_access", {30'd0, psel_o, penable_o}, 32'd3);
                chk("t1_fields", {15'd0, pwrite_o, paddr_o, pwdata_o}, {15'd0, 1'b1, 8'h05, 8'h1F});
                @(negedge pclk_i);
                chk("t1_done", {29'd0, req0_done_o, req0_err_o, req1_done_o}, 32'd4);
                chk("t1_idle_bus", {30'd0, psel_o, penable_o}, 32'd0);
            end
        join
        wait_idle();

        // 2: req1 read, data routed to rdata1 only
        slv_rdata = 8'hA5;
        drive_req(1, 1'b0, 8'h02, 8'h00);
        wait_idle();

        // 3: pointer is back on req0 here (each lone transfer flipped it once)
        acc_ord.delete();
        slv_rdata = 8'h00;
        fork
            begin
                drive_req(0, 1'b1, 8'h04, 8'h40);
                drive_req(0, 1'b1, 8'h04, 8'h41);
            end
            drive_req(1, 1'b1, 8'h03, 8'h30);
        join
        wait_idle();
        fork
            drive_req(0, 1'b1, 8'h06, 8'h60);
            drive_req(1, 1'b1, 8'h07, 8'h70);
        join
        wait_idle();
        chk("t3_count", acc_ord.size(), 32'd5);
        if (acc_ord.size() == 5) begin
            chk("t3_ord0", acc_ord[0], 32'd0);
            chk("t3_ord1", acc_ord[1], 32'd1);
            chk("t3_ord2", acc_ord[2], 32'd0);
            chk("t3_ord3", acc_ord[3], 32'd1);
            chk("t3_ord4", acc_ord[4], 32'd0);
        end

        // 4: three wait states
        slv_wait  = 3;
        slv_rdata = 8'h3C;
        fork
            drive_req(0, 1'b0, 8'h11, 8'h00);
            measure_access(8'h11, nacc);
        join
        chk("t4_access_len", nacc, 32'd4);
        wait_idle();

        // 5: pready stuck low -> abort after TO cycles, rdata1 kept
        slv_wait  = 255;
        slv_rdata = 8'h99;
        fork
            drive_req(1, 1'b0, 8'h22, 8'h00);
            measure_access(8'h22, nacc);
        join
        chk("t5_access_len", nacc, TO);
        wait_idle();

        // mixed traffic
        for (int k = 0; k < 6; k++) begin
            slv_wait  = $urandom_range(0, 2);
            slv_rdata = 8'($urandom_range(0, 255));
            drive_req($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            wait_idle();
        end

        // 6: reset during ACCESS
        slv_wait = 255;
        drive_req(0, 1'b1, 8'h30, 8'h5A);
        for (int i = 0; i < 10 && !(psel_o && penable_o); i++) @(negedge pclk_i);
        chk("t6_in_access", {30'd0, psel_o, penable_o}, 32'd3);
        #2;
        preset_ni = 1'b0;
        #1;
        chk("t6_bus_drop", {30'd0, psel_o, penable_o}, 32'd0);
        sb.delete();
        acc_ord.delete();
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        slv_wait  = 0;
        @(negedge pclk_i);
        @(negedge pclk_i);
        preset_ni = 1'b1;
        repeat (6) @(posedge pclk_i);
        #1;
        chk("t6_quiet", {30'd0, req1_done_o, req0_done_o}, 32'd0);
        slv_rdata = 8'h5E;
        fork
            drive_req(0, 1'b0, 8'h08, 8'h00);
            drive_req(1, 1'b1, 8'h09, 8'h90);
        join
        wait_idle();
        chk("t6_count", acc_ord.size(), 32'd2);
        if (acc_ord.size() == 2) chk("t6_first", acc_ord[0], 32'd0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
